// File: rtl/regfile_bank.sv
`timescale 1ns/1ps
// regfile_bank: REG_COUNT x DATA_BUS_WIDTH register bank with two combinational
//   read ports, one synchronous WRITE/INC/DEC port with zero/carry flags, and a
//   one-register-per-cycle clear sweep that drops ops and clear requests while busy.
// Ports: clock/reset (async active-low); op, reg_in_sel, reg_data_in (update port);
//   reg_1_out_sel/reg_1_out, reg_2_out_sel/reg_2_out (read ports); clear_start, busy;
//   zero_flag, carry_flag (result of last INC/DEC).
// Macro REGFILE_BYPASS_EN: when defined, a pending WRITE is forwarded to a read port
//   that selects its target in the same cycle (INC/DEC are never forwarded).
module regfile_bank #(
  parameter int DATA_BUS_WIDTH = 8,
  parameter int REG_COUNT      = 8,
  localparam int SEL_WIDTH     = $clog2(REG_COUNT)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [1:0]                op,
  input  logic [SEL_WIDTH-1:0]      reg_in_sel,
  input  logic [DATA_BUS_WIDTH-1:0] reg_data_in,
  input  logic [SEL_WIDTH-1:0]      reg_1_out_sel,
  input  logic [SEL_WIDTH-1:0]      reg_2_out_sel,
  input  logic                      clear_start,
  output logic [DATA_BUS_WIDTH-1:0] reg_1_out,
  output logic [DATA_BUS_WIDTH-1:0] reg_2_out,
  output logic                      busy,
  output logic                      zero_flag,
  output logic                      carry_flag
);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_INC   = 2'b10;
  localparam logic [1:0] OP_DEC   = 2'b11;

  localparam logic [SEL_WIDTH-1:0]    LAST_IDX = SEL_WIDTH'(REG_COUNT - 1);
  localparam logic [DATA_BUS_WIDTH:0] ONE_EXT  = (DATA_BUS_WIDTH + 1)'(1);

  state_e                    state_q, state_d;
  logic [SEL_WIDTH-1:0]      cnt_q, cnt_d;
  logic [DATA_BUS_WIDTH-1:0] regs_q [REG_COUNT];
  logic [DATA_BUS_WIDTH-1:0] regs_d [REG_COUNT];
  logic                      zero_q, zero_d;
  logic                      carry_q, carry_d;

  logic [DATA_BUS_WIDTH-1:0] tgt_val;
  logic [DATA_BUS_WIDTH-1:0] tgt_res;
  logic                      tgt_carry;

  assign tgt_val = regs_q[reg_in_sel];

  // Next-state: ops only act in IDLE; an op and clear_start in the same cycle both
  // take effect, so the sweep that follows wipes the op's result.
  always_comb begin
    regs_d    = regs_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    zero_d    = zero_q;
    carry_d   = carry_q;
    tgt_res   = '0;
    tgt_carry = 1'b0;
    case (state_q)
      IDLE: begin
        case (op)
          OP_WRITE: regs_d[reg_in_sel] = reg_data_in;
          OP_INC: begin
            // The extra top bit is the carry out of all-ones.
            {tgt_carry, tgt_res} = {1'b0, tgt_val} + ONE_EXT;
            regs_d[reg_in_sel]   = tgt_res;
            zero_d               = (tgt_res == '0);
            carry_d              = tgt_carry;
          end
          OP_DEC: begin
            // The extra top bit becomes the borrow out of zero.
            {tgt_carry, tgt_res} = {1'b0, tgt_val} - ONE_EXT;
            regs_d[reg_in_sel]   = tgt_res;
            zero_d               = (tgt_res == '0);
            carry_d              = tgt_carry;
          end
          default: ;
        endcase
        if (clear_start) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        regs_d[cnt_q] = '0;
        if (cnt_q == LAST_IDX) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs_q[i] <= '0;
      end
      state_q <= IDLE;
      cnt_q   <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      regs_q  <= regs_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
    end
  end

  assign busy       = (state_q == CLEAR);
  assign zero_flag  = zero_q;
  assign carry_flag = carry_q;

`ifdef REGFILE_BYPASS_EN
  logic wr_fwd;
  // Reset gates the forward path so the read ports show zero while reset is held.
  assign wr_fwd = reset && (op == OP_WRITE) && (state_q == IDLE);

  always_comb begin
    reg_1_out = regs_q[reg_1_out_sel];
    reg_2_out = regs_q[reg_2_out_sel];
    if (wr_fwd && (reg_1_out_sel == reg_in_sel)) begin
      reg_1_out = reg_data_in;
    end
    if (wr_fwd && (reg_2_out_sel == reg_in_sel)) begin
      reg_2_out = reg_data_in;
    end
  end
`else
  assign reg_1_out = regs_q[reg_1_out_sel];
  assign reg_2_out = regs_q[reg_2_out_sel];
`endif

endmodule

// File: tb/tb_regfile_bank.sv
`timescale 1ns/1ps
// Bench for regfile_bank: directed scenarios from the test plan plus a randomized
// op/clear stream, all checked against an array-based reference model.
module tb_regfile_bank;

  localparam int W = 8;
  localparam int N = 8;
  localparam int S = 3;
  localparam int MOD = 1 << W;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [S-1:0] reg_in_sel = '0;
  logic [W-1:0] reg_data_in = '0;
  logic [S-1:0] reg_1_out_sel = '0;
  logic [S-1:0] reg_2_out_sel = '0;
  logic         clear_start = 1'b0;
  logic [W-1:0] reg_1_out;
  logic [W-1:0] reg_2_out;
  logic         busy;
  logic         zero_flag;
  logic         carry_flag;

  int vectors    = 0;
  int miscompares = 0;

  // Reference model: register contents as plain integers, sweep as a busy bit
  // plus the index that the next sweep edge will clear.
  int m_mem [N];
  bit m_busy;
  int m_idx;
  bit m_zf;
  bit m_cf;

  regfile_bank #(.DATA_BUS_WIDTH(W), .REG_COUNT(N)) dut (
    .clock        (clock),
    .reset        (reset),
    .op           (op),
    .reg_in_sel   (reg_in_sel),
    .reg_data_in  (reg_data_in),
    .reg_1_out_sel(reg_1_out_sel),
    .reg_2_out_sel(reg_2_out_sel),
    .clear_start  (clear_start),
    .reg_1_out    (reg_1_out),
    .reg_2_out    (reg_2_out),
    .busy         (busy),
    .zero_flag    (zero_flag),
    .carry_flag   (carry_flag)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, required completion");
    $fatal(1);
  end

  function automatic logic [W-1:0] exp_read(input int sel);
`ifdef REGFILE_BYPASS_EN
    if (!m_busy && op == 2'b01 && sel == int'(reg_in_sel)) return reg_data_in;
`endif
    return W'(m_mem[sel]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_mem[i] = 0;
    m_busy = 0;
    m_idx  = 0;
    m_zf   = 0;
    m_cf   = 0;
  endtask

  // Predict the effect of the coming edge from the current inputs, wait for it,
  // then commit the prediction 1ns after the edge.
  task automatic tick();
    int nm [N];
    bit nb, nz, nc;
    int ni, v, s;
    nm = m_mem; nb = m_busy; ni = m_idx; nz = m_zf; nc = m_cf;
    s = int'(reg_in_sel);
    if (!m_busy) begin
      case (op)
        2'b01: nm[s] = int'(reg_data_in);
        2'b10: begin
          v = m_mem[s] + 1;
          nc = (v >= MOD);
          nm[s] = v % MOD;
          nz = (nm[s] == 0);
        end
        2'b11: begin
          v = m_mem[s] - 1;
          nc = (v < 0);
          nm[s] = (v + MOD) % MOD;
          nz = (nm[s] == 0);
        end
        default: ;
      endcase
      if (clear_start) begin
        nb = 1;
        ni = 0;
      end
    end else begin
      nm[m_idx] = 0;
      if (m_idx == N - 1) begin
        nb = 0;
        ni = 0;
      end else begin
        ni = m_idx + 1;
      end
    end
    @(posedge clock);
    #1;
    m_mem = nm; m_busy = nb; m_idx = ni; m_zf = nz; m_cf = nc;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    model_reset();
    #12;
    vectors++;
    if (busy !== 1'b0 || zero_flag !== 1'b0 || carry_flag !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_status: busy/zf/cf = %b%b%b, required 000", busy, zero_flag, carry_flag);
    end
    for (int i = 0; i < N; i++) begin
      reg_1_out_sel = S'(i);
      reg_2_out_sel = S'(N - 1 - i);
      #0.2;
      vectors++;
      if (reg_1_out !== 8'h00 || reg_2_out !== 8'h00) begin
        miscompares++;
        $display("FAIL reset_regs[%0d]: r1=%h r2=%h, required 00 00", i, reg_1_out, reg_2_out);
      end
    end
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_write();
    op = 2'b01; reg_in_sel = 3; reg_data_in = 8'hA5;
    reg_1_out_sel = 3; reg_2_out_sel = 3;
    #0.2;
    vectors++;
    if (reg_1_out !== exp_read(3)) begin
      miscompares++;
      $display("FAIL write_pre_edge: r1=%h, required %h", reg_1_out, exp_read(3));
    end
    tick();
    op = 2'b00;
    #0.2;
    vectors++;
    if (reg_1_out !== 8'hA5 || reg_2_out !== 8'hA5) begin
      miscompares++;
      $display("FAIL write_r3: r1=%h r2=%h, required a5 a5", reg_1_out, reg_2_out);
    end
  endtask

  task automatic test_inc_wrap();
    op = 2'b01; reg_in_sel = 1; reg_data_in = 8'hFF; reg_1_out_sel = 1;
    tick();
    op = 2'b10;
    tick();
    #0.2;
    vectors++;
    if (reg_1_out !== 8'h00 || zero_flag !== 1'b1 || carry_flag !== 1'b1) begin
      miscompares++;
      $display("FAIL inc_wrap: r1=%h zf=%b cf=%b, required 00 1 1", reg_1_out, zero_flag, carry_flag);
    end
    tick();
    op = 2'b00;
    #0.2;
    vectors++;
    if (reg_1_out !== 8'h01 || zero_flag !== 1'b0 || carry_flag !== 1'b0) begin
      miscompares++;
      $display("FAIL inc_after_wrap: r1=%h zf=%b cf=%b, required 01 0 0", reg_1_out, zero_flag, carry_flag);
    end
  endtask

  task automatic test_dec_wrap();
    op = 2'b01; reg_in_sel = 2; reg_data_in = 8'h00; reg_2_out_sel = 2;
    tick();
    op = 2'b11;
    tick();
    op = 2'b00;
    #0.2;
    vectors++;
    if (reg_2_out !== 8'hFF || zero_flag !== 1'b0 || carry_flag !== 1'b1) begin
      miscompares++;
      $display("FAIL dec_wrap: r2=%h zf=%b cf=%b, required ff 0 1", reg_2_out, zero_flag, carry_flag);
    end
  endtask

  task automatic test_bypass();
    logic [W-1:0] want;
    op = 2'b01; reg_in_sel = 4; reg_data_in = 8'h10;
    tick();
    reg_data_in = 8'h5A; reg_1_out_sel = 4; reg_2_out_sel = 0;
`ifdef REGFILE_BYPASS_EN
    want = 8'h5A;
`else
    want = 8'h10;
`endif
    #0.2;
    vectors++;
    if (reg_1_out !== want || reg_2_out !== exp_read(0)) begin
      miscompares++;
      $display("FAIL bypass_pre_edge: r1=%h r2=%h, required %h %h", reg_1_out, reg_2_out, want, exp_read(0));
    end
    tick();
    op = 2'b00;
    #0.2;
    vectors++;
    if (reg_1_out !== 8'h5A) begin
      miscompares++;
      $display("FAIL bypass_post_edge: r1=%h, required 5a", reg_1_out);
    end
  endtask

  task automatic test_clear();
    bit zf0, cf0;
    for (int i = 0; i < N; i++) begin
      op = 2'b01; reg_in_sel = S'(i); reg_data_in = W'((i + 1) * 8'h11);
      tick();
    end
    op = 2'b00; clear_start = 1'b1;
    zf0 = m_zf; cf0 = m_cf;
    tick();
    clear_start = 1'b0;
    for (int c = 0; c < N; c++) begin
      // Writes and further clear requests during the sweep must be dropped.
      op = 2'b01; reg_in_sel = S'($urandom_range(0, N - 1)); reg_data_in = W'($urandom);
      clear_start = 1'b1;
      #0.2;
      vectors++;
      if (busy !== 1'b1) begin
        miscompares++;
        $display("FAIL clear_busy[%0d]: busy=%b, required 1", c, busy);
      end
      tick();
      for (int i = 0; i < N; i++) begin
        reg_1_out_sel = S'(i);
        #0.2;
        vectors++;
        if (reg_1_out !== exp_read(i)) begin
          miscompares++;
          $display("FAIL clear_reg[c%0d][%0d]: r1=%h, required %h", c, i, reg_1_out, exp_read(i));
        end
      end
    end
    op = 2'b00; clear_start = 1'b0;
    #0.2;
    vectors++;
    if (busy !== 1'b0 || zero_flag !== zf0 || carry_flag !== cf0) begin
      miscompares++;
      $display("FAIL clear_end: busy/zf/cf=%b%b%b, required 0%b%b", busy, zero_flag, carry_flag, zf0, cf0);
    end
    for (int i = 0; i < N; i++) begin
      reg_2_out_sel = S'(i);
      #0.2;
      vectors++;
      if (reg_2_out !== 8'h00) begin
        miscompares++;
        $display("FAIL clear_final[%0d]: r2=%h, required 00", i, reg_2_out);
      end
    end
  endtask

  task automatic test_reset_mid_sweep();
    int cycles;
    for (int i = 0; i < N; i++) begin
      op = 2'b01; reg_in_sel = S'(i); reg_data_in = W'($urandom_range(1, 255));
      tick();
    end
    op = 2'b10; reg_in_sel = 0;
    tick();
    op = 2'b00; clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    tick(); tick(); tick();
    #2;
    reset = 1'b0;
    model_reset();
    #0.2;
    vectors++;
    if (busy !== 1'b0 || zero_flag !== 1'b0 || carry_flag !== 1'b0) begin
      miscompares++;
      $display("FAIL midsweep_reset_status: busy/zf/cf=%b%b%b, required 000", busy, zero_flag, carry_flag);
    end
    for (int i = 0; i < N; i++) begin
      reg_1_out_sel = S'(i);
      #0.2;
      vectors++;
      if (reg_1_out !== 8'h00) begin
        miscompares++;
        $display("FAIL midsweep_reset_reg[%0d]: r1=%h, required 00", i, reg_1_out);
      end
    end
    @(negedge clock);
    reset = 1'b1;
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    cycles = 0;
    while (busy === 1'b1 && cycles < 20) begin
      tick();
      cycles++;
    end
    vectors++;
    if (cycles != N || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL midsweep_next_sweep_len: %0d cycles (busy=%b), required %0d", cycles, busy, N);
    end
  endtask

  task automatic test_random();
    int guard;
    for (int n = 0; n < 300; n++) begin
      op            = 2'($urandom_range(0, 3));
      reg_in_sel    = S'($urandom_range(0, N - 1));
      reg_data_in   = W'($urandom);
      reg_1_out_sel = S'($urandom_range(0, N - 1));
      reg_2_out_sel = ($urandom_range(0, 3) == 0) ? reg_in_sel : S'($urandom_range(0, N - 1));
      clear_start   = ($urandom_range(0, 19) == 0);
      #0.2;
      vectors++;
      if (reg_1_out !== exp_read(reg_1_out_sel) || reg_2_out !== exp_read(reg_2_out_sel) ||
          busy !== m_busy || zero_flag !== m_zf || carry_flag !== m_cf) begin
        miscompares++;
        $display("FAIL random[%0d]: r1=%h r2=%h busy=%b zf=%b cf=%b, required %h %h %b %b %b",
                 n, reg_1_out, reg_2_out, busy, zero_flag, carry_flag,
                 exp_read(reg_1_out_sel), exp_read(reg_2_out_sel), m_busy, m_zf, m_cf);
      end
      tick();
    end
    op = 2'b00; clear_start = 1'b0;
    guard = 0;
    while (m_busy && guard < 20) begin
      tick();
      guard++;
    end
    vectors++;
    if (busy !== m_busy) begin
      miscompares++;
      $display("FAIL random_drain: busy=%b, required %b", busy, m_busy);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_inc_wrap();
    test_dec_wrap();
    test_bypass();
    test_clear();
    test_reset_mid_sweep();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/regfile_bank.md
# regfile_bank

Parametrised general-purpose register bank for the datapath, with two combinational read ports and one synchronous write port. It adds in-place increment/decrement with zero and carry flags, and a multi-cycle clear sequencer with a busy indication. It sits between the decoder/control FSM, which drives the select and op lines, and the ALU, which consumes both read ports and supplies write data.

## Interface
- DATA_BUS_WIDTH, 8, register width in bits (≥ 2)
- REG_COUNT, 8, number of registers; power of two, ≥ 2
- SEL_WIDTH, $clog2(REG_COUNT), select width; localparam, derived, not overridable

- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- op  in  2  operation: 00 NOP, 01 WRITE, 10 INC, 11 DEC
- reg_in_sel  in  SEL_WIDTH  target register for WRITE/INC/DEC
- reg_data_in  in  DATA_BUS_WIDTH  write data for WRITE
- reg_1_out_sel  in  SEL_WIDTH  read port 1 select
- reg_2_out_sel  in  SEL_WIDTH  read port 2 select
- clear_start  in  1  request a full clear sweep
- reg_1_out  out  DATA_BUS_WIDTH  contents of reg_1_out_sel
- reg_2_out  out  DATA_BUS_WIDTH  contents of reg_2_out_sel
- busy  out  1  clear sweep in progress
- zero_flag  out  1  result of last INC/DEC was zero
- carry_flag  out  1  last INC/DEC wrapped

## Operation
- **Reads:** combinational from the selected register. Both ports may select the same register.
- **WRITE:** at the clock edge, reg[reg_in_sel] ← reg_data_in. Flags are unchanged.
- **INC/DEC:**
  - At the clock edge, reg[reg_in_sel] ← reg ± 1, modulo 2^DATA_BUS_WIDTH.
  - zero_flag ← (result == 0).
  - carry_flag ← 1 on INC from all-ones or DEC from zero, else 0.
- **NOP:** no state change.
- **FSM states:** IDLE, CLEAR.
  - IDLE → CLEAR when clear_start=1 at a clock edge. The sweep counter loads 0.
  - In CLEAR, each edge sets reg[counter] ← 0 and increments the counter.
  - After clearing index REG_COUNT-1, the FSM returns to IDLE and the counter returns to 0.
  - Flags are not affected by the sweep.
- busy = (state == CLEAR), decoded directly from the state register.
- **While busy:**
  - op is ignored (dropped, not queued).
  - clear_start is ignored.
  - Reads still return current contents, so partially cleared values are visible.
- **clear_start and a non-NOP op in the same IDLE cycle:** the op executes at that edge. The sweep begins at the following edge and clears the op's result.

## Timing
- **Reset (asynchronous assert):** all registers = 0, reg_1_out = reg_2_out = 0, busy = 0, zero_flag = 0, carry_flag = 0, state IDLE, counter 0.
- **Reset mid-sweep:** the sweep aborts immediately and all of the reset values above apply.
- **Reset deassert:** the first op is accepted at the first rising edge after deassertion.
- **Write/INC/DEC latency:** 1 cycle. The new value is visible on the read ports after the edge.
- **Clear sweep:** occupies exactly REG_COUNT cycles. busy rises after the edge that sampled clear_start and falls after the edge that cleared index REG_COUNT-1.
- **Back-to-back ops on the same register:** allowed every cycle. Each op sees the previous op's result.

## Configuration
- Macro: REGFILE_BYPASS_EN.
- **Defined:**
  - A read port whose select equals reg_in_sel, while op = WRITE and busy = 0, returns reg_data_in combinationally in the same cycle (write-first).
  - INC/DEC are not bypassed.
- **Undefined:** read ports always return stored contents, so the old value is visible until the next edge.

## Test plan
- **Reset and write:** assert reset, then release. All reads = 0, busy = 0, flags = 0. WRITE 0xA5 to r3, then read r3 on both ports → 0xA5 after one edge.
- **Increment wrap:** WRITE 0xFF to r1, then INC r1 → r1 = 0x00, zero_flag = 1, carry_flag = 1. Then INC → r1 = 0x01, zero_flag = 0, carry_flag = 0.
- **Decrement wrap:** DEC r2 from 0 → r2 = 0xFF, carry_flag = 1, zero_flag = 0.
- **Clear sweep:**
  - Fill r0..r7 with 0x11..0x88, then pulse clear_start.
  - busy stays high for exactly 8 cycles and register k reads 0 from sweep cycle k+1.
  - A WRITE issued during the sweep leaves its target unchanged.
  - At the end, all registers are 0.
- **Reset mid-sweep:** start a sweep, then assert reset in sweep cycle 3 → busy = 0 and all registers = 0 immediately. The next sweep runs a full 8 cycles.
- **Bypass (run with and without REGFILE_BYPASS_EN):** r4 = 0x10. Drive WRITE 0x5A to r4 with reg_1_out_sel = 4 → reg_1_out = 0x5A before the edge with the macro defined, and 0x10 without it.
